dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the per-thread LSU valid/ready data-memory protocol.
//  - Serves NUM_CONSUMERS LSU ports with round-robin arbitration.
//  - Uses one internal single-port byte array.
//  - Has a fixed, parameterised access latency.
//  - Sits between the LSUs of a core and data memory.
//  - Replaces the testbench memory model in unit and core-level simulation.
// PARAMETERS
//  NUM_CONSUMERS  4  number of LSU request ports
//  ADDR_BITS      8  address width; array depth = 2**ADDR_BITS
//  DATA_BITS      8  data width
//  LATENCY        2  edges from request capture to ready pulse; legal range >= 1
// PORTS
//  clk                     in   1        clock, all state on rising edge
//  reset                   in   1        asynchronous, active-low reset
//  consumer_read_valid     in   N        per-consumer read request; held until its ready pulse
//  consumer_read_address   in   N*A      packed; consumer i at [i*A +: A]
//  consumer_read_ready     out  N        one-cycle read-complete pulse
//  consumer_read_data      out  N*D      packed read data; holds last value returned to i
//  consumer_write_valid    in   N        per-consumer write request; held until its ready pulse
//  consumer_write_address  in   N*A      packed write address
//  consumer_write_data     in   N*D      packed write data
//  consumer_write_ready    out  N        one-cycle write-complete pulse
//  busy                    out  1        high whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - All ready = 0, all read_data = 0, busy = 0.
//   - FSM -> IDLE, counter = 0, rr pointer = N-1, so consumer 0 wins first.
//   - Array contents are not reset.
//   - A request in flight is dropped; its write is not committed.
//  FSM states: IDLE -> ACCESS -> RESPOND -> IDLE.
//  IDLE:
//   - req[i] = read_valid[i] | write_valid[i].
//   - If any req: grant g = first requester searching from rr+1 upward, modulo N.
//   - Latch g, op, address and write data. Set rr = g, cnt = LATENCY-1, go to ACCESS.
//   - If read_valid[g] and write_valid[g] are both high, the read wins. The write stays pending.
//  ACCESS:
//   - cnt != 0: decrement cnt.
//   - cnt == 0, read: read_data[g] <= mem[addr] and read_ready[g] <= 1.
//   - cnt == 0, write: mem[addr] <= wdata and write_ready[g] <= 1.
//   - Go to RESPOND.
//  RESPOND:
//   - Clear the ready pulse, which lasts exactly one cycle. Go to IDLE.
//   - The served consumer drops valid on the same edge. The next capture is no earlier than the following edge.
//  Timing:
//   - Capture at edge E0; ready is high during the cycle after edge E0+LATENCY.
//   - One transaction per LATENCY+2 cycles.
//  Rules:
//   - Only one ready bit in the whole block is high in any cycle.
//   - Ready is never asserted to a consumer whose valid was low at capture.
//   - Inputs are sampled only at capture. Changes to address/data while waiting are ignored.
//   - Addresses use all ADDR_BITS. 2**A-1 is a legal location; there is no wrap or overflow logic.
//   - read_data[i] changes only on a read to i. Other consumers' data is untouched.
//   - A read that follows a write to the same address returns the new data.
// TESTING
//  1 Write: c0 writes 0x5A to 0x10.
//    -> write_ready[0] pulses exactly 1 cycle, LATENCY edges after capture.
//  2 Read-back: c0 then reads 0x10.
//    -> read_ready[0] pulses and read_data[0] == 0x5A; other read_data stay 0.
//  3 Round robin: c0..c3 all read at once after reset.
//    -> service order 0,1,2,3. Then c1 and c3 request again -> order 1,3 (rr = 3 -> 0 idle, 1 first).
//  4 Same consumer both ops: c2 asserts read of 0x20 and write of 0x77 to 0x20.
//    -> read served first (old data). Then the write is served. A later read returns 0x77.
//  5 Top address: write 0xC3 to 0xFF, read 0xFF -> 0xC3. Address 0x00 is unaffected.
//  6 Reset mid-access: drop reset during ACCESS of a write to 0x30.
//    -> ready stays 0, busy = 0 immediately. mem[0x30] is unchanged. The next request is served normally.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Per-consumer LSU read/write valid/ready bundle between the LSUs and dmem_responder.
// The LSU side drives the master modport; the responder takes the slave modport.
interface dmem_responder_if #(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8
);
    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

    modport master (
        output consumer_read_valid, consumer_read_address,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready
    );

    modport slave (
        input  consumer_read_valid, consumer_read_address,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_read_ready, consumer_read_data, consumer_write_ready
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: round-robin arbitration over LSU ports onto one single-port
// byte array, with a fixed access latency and a one-cycle ready pulse per transaction.
module dmem_responder #(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned LATENCY       = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus,
    output logic            busy
);
    localparam int unsigned IdxW  = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned Depth = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

    state_e                             state_q, state_d;
    logic [CntW-1:0]                    cnt_q, cnt_d;
    logic [IdxW-1:0]                    rr_q, rr_d;
    logic [IdxW-1:0]                    grant_q, grant_d;
    logic [IdxW-1:0]                    pick;
    logic                               found;
    logic                               is_read_q, is_read_d;
    logic [ADDR_BITS-1:0]               addr_q, addr_d;
    logic [DATA_BITS-1:0]               wdata_q, wdata_d;
    logic [NUM_CONSUMERS-1:0]           read_ready_q, read_ready_d;
    logic [NUM_CONSUMERS-1:0]           write_ready_q, write_ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] read_data_q, read_data_d;
    logic                               mem_we;
    logic [DATA_BITS-1:0]               mem [Depth];

    function automatic logic [IdxW-1:0] wrap_idx(logic [IdxW-1:0] base, int unsigned off);
        return IdxW'((32'(base) + off) % NUM_CONSUMERS);
    endfunction

    // Search starts just past the last grant, so the previous winner goes last.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        for (int unsigned k = 1; k <= NUM_CONSUMERS; k++) begin
            if (!found && (bus.consumer_read_valid[wrap_idx(rr_q, k)] ||
                           bus.consumer_write_valid[wrap_idx(rr_q, k)])) begin
                found = 1'b1;
                pick  = wrap_idx(rr_q, k);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rr_d          = rr_q;
        grant_d       = grant_q;
        is_read_d     = is_read_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        read_ready_d  = '0;
        write_ready_d = '0;
        read_data_d   = read_data_q;
        mem_we        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d   = pick;
                    rr_d      = pick;
                    // A consumer with both ops pending gets its read first.
                    is_read_d = bus.consumer_read_valid[pick];
                    addr_d    = bus.consumer_read_valid[pick]
                              ? bus.consumer_read_address[pick*ADDR_BITS +: ADDR_BITS]
                              : bus.consumer_write_address[pick*ADDR_BITS +: ADDR_BITS];
                    wdata_d   = bus.consumer_write_data[pick*DATA_BITS +: DATA_BITS];
                    cnt_d     = CntW'(LATENCY - 1);
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    if (is_read_q) begin
                        read_data_d[grant_q*DATA_BITS +: DATA_BITS] = mem[addr_q];
                        read_ready_d[grant_q] = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        write_ready_d[grant_q] = 1'b1;
                    end
                    state_d = StRespond;
                end
            end
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            rr_q          <= IdxW'(NUM_CONSUMERS - 1);
            grant_q       <= '0;
            is_read_q     <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            read_ready_q  <= '0;
            write_ready_q <= '0;
            read_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_q          <= rr_d;
            grant_q       <= grant_d;
            is_read_q     <= is_read_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            read_ready_q  <= read_ready_d;
            write_ready_q <= write_ready_d;
            read_data_q   <= read_data_d;
        end
    end

    // Array contents survive reset; only committed writes change them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.consumer_read_ready  = read_ready_q;
    assign bus.consumer_write_ready = write_ready_q;
    assign bus.consumer_read_data   = read_data_q;
    assign busy                     = (state_q != StIdle);
endmodule
